// File: rtl/index_video_pkg.sv
// index_video_pkg: shared widths, default 640x480@60 timing, pixel types and
// the fixed colour-index palette used by the frame-buffer scan-out path.
package index_video_pkg;

  // Frame-buffer geometry
  localparam int unsigned FB_ADDR_W = 19;
  localparam int unsigned FB_IDX_W  = 3;
  localparam int unsigned RGB_W     = 8;

  // Raster counters are sized for the 800x525 default raster
  localparam int unsigned CNT_W = 10;

  // Default 640x480@60 timing (25 MHz pixel clock)
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned FB_PIXELS = DEF_H_VISIBLE * DEF_V_VISIBLE;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [FB_IDX_W-1:0]  fb_idx_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

  // Per-pixel control that travels alongside the memory read
  typedef struct packed {
    logic visible;
    logic hs_n;
    logic vs_n;
    logic first;
  } pix_flags_t;

  // Blank, syncs inactive: what an empty pipeline slot looks like
  localparam pix_flags_t FLAGS_IDLE = '{visible: 1'b0, hs_n: 1'b1, vs_n: 1'b1, first: 1'b0};
  localparam rgb_t       RGB_BLACK  = '0;

  // Each index bit switches one primary fully on or off
  function automatic rgb_t palette_rgb(input fb_idx_t idx);
    rgb_t c;
    c.r = idx[2] ? 8'hFF : 8'h00;
    c.g = idx[1] ? 8'hFF : 8'h00;
    c.b = idx[0] ? 8'hFF : 8'h00;
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical raster counters and the issue-stage
// flags derived from them (visible, raw active-low syncs, first pixel,
// vertical blank and end-of-frame).
// With INDEX_READER_TEST_PATTERN_EN defined it also exports the 64-pixel
// colour-bar index h_count[8:6].
module vga_timing_gen
  import index_video_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic    clock,
  input  logic    reset,
  output logic    visible,
  output logic    hs_n,
  output logic    vs_n,
  output logic    first_pixel,
  output logic    in_vblank,
`ifdef INDEX_READER_TEST_PATTERN_EN
  output fb_idx_t h_bar,
`endif
  output logic    frame_end
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS_END  = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS_END  = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_FIRST   = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_LAST    = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_FIRST   = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_LAST    = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  cnt_t h_count;
  cnt_t v_count;
  logic line_end;

  assign line_end = (h_count == H_LAST);

  // Raster scan: h wraps at end of line and steps v; v wraps with the last line
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (line_end) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  assign visible     = (h_count < H_VIS_END) && (v_count < V_VIS_END);
  assign hs_n        = !((h_count >= HS_FIRST) && (h_count <= HS_LAST));
  assign vs_n        = !((v_count >= VS_FIRST) && (v_count <= VS_LAST));
  assign first_pixel = (h_count == '0) && (v_count == '0);
  assign in_vblank   = (v_count >= V_VIS_END);
  assign frame_end   = line_end && (v_count == V_LAST);

`ifdef INDEX_READER_TEST_PATTERN_EN
  assign h_bar = h_count[8:6];
`endif

endmodule

// File: rtl/index_frame_reader.sv
// index_frame_reader: scans the 3-bit colour-index frame buffer out in raster
// order, aligns per-pixel timing flags with the memory read latency and maps
// each index through the fixed palette into registered VGA outputs.
// vblank is the undelayed (issue-stage) warning for the writer side.
// READ_LATENCY is legal in 1..4.
// Optional: define INDEX_READER_TEST_PATTERN_EN to add the test_pattern input,
// which replaces the memory index with 64-pixel colour bars.
module index_frame_reader
  import index_video_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned H_VISIBLE    = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT      = DEF_H_FRONT,
  parameter int unsigned H_SYNC       = DEF_H_SYNC,
  parameter int unsigned H_BACK       = DEF_H_BACK,
  parameter int unsigned V_VISIBLE    = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT      = DEF_V_FRONT,
  parameter int unsigned V_SYNC       = DEF_V_SYNC,
  parameter int unsigned V_BACK       = DEF_V_BACK
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef INDEX_READER_TEST_PATTERN_EN
  input  logic                 test_pattern,
`endif
  output logic [FB_ADDR_W-1:0] mem_raddr,
  input  logic [FB_IDX_W-1:0]  mem_rdata,
  output logic [RGB_W-1:0]     vga_r,
  output logic [RGB_W-1:0]     vga_g,
  output logic [RGB_W-1:0]     vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic                 vblank,
  output logic                 frame_start
);

  // Final visible address; the counter saturates here until the frame wraps
  localparam fb_addr_t ADDR_LAST = fb_addr_t'(H_VISIBLE * V_VISIBLE - 1);

  pix_flags_t issue_flags;
  logic       in_vblank;
  logic       frame_end;
  fb_addr_t   rd_addr;

`ifdef INDEX_READER_TEST_PATTERN_EN
  fb_idx_t    h_bar;
`endif

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .visible     (issue_flags.visible),
    .hs_n        (issue_flags.hs_n),
    .vs_n        (issue_flags.vs_n),
    .first_pixel (issue_flags.first),
    .in_vblank   (in_vblank),
`ifdef INDEX_READER_TEST_PATTERN_EN
    .h_bar       (h_bar),
`endif
    .frame_end   (frame_end)
  );

  // Raster-order read address: advances on visible pixels, holds in blanking,
  // saturates on the last pixel and restarts when the frame wraps
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr <= '0;
    end else if (frame_end) begin
      rd_addr <= '0;
    end else if (issue_flags.visible && (rd_addr != ADDR_LAST)) begin
      rd_addr <= rd_addr + 1'b1;
    end
  end

  assign mem_raddr = rd_addr;

  // Delay line: carries the issue-stage flags READ_LATENCY cycles so they meet
  // the index returned for the same address
  pix_flags_t flag_dly [READ_LATENCY];

  always_ff @(posedge clock) begin
    // NOTE: the delay line is cleared on reset, not left to drain, so a pixel
    // in flight when reset hits can never reach the display.
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) flag_dly[i] <= FLAGS_IDLE;
    end else begin
      flag_dly[0] <= issue_flags;
      for (int i = 1; i < READ_LATENCY; i++) flag_dly[i] <= flag_dly[i-1];
    end
  end

`ifdef INDEX_READER_TEST_PATTERN_EN
  // Colour-bar index travels with the flags so the bar matches the pixel
  fb_idx_t bar_dly [READ_LATENCY];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) bar_dly[i] <= '0;
    end else begin
      bar_dly[0] <= h_bar;
      for (int i = 1; i < READ_LATENCY; i++) bar_dly[i] <= bar_dly[i-1];
    end
  end
`endif

  pix_flags_t aligned;
  fb_idx_t    pix_idx;
  rgb_t       pix_rgb;

  assign aligned = flag_dly[READ_LATENCY-1];

  // Index source select and palette lookup; blank pixels are forced black
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    pix_idx = mem_rdata;
    pix_rgb = RGB_BLACK;
`ifdef INDEX_READER_TEST_PATTERN_EN
    if (test_pattern) pix_idx = bar_dly[READ_LATENCY-1];
`endif
    if (aligned.visible) pix_rgb = palette_rgb(pix_idx);
  end

  // Output register: colour, syncs and markers leave together; vblank is the
  // registered issue-stage flag so the writer sees it ahead of the display
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      vga_r       <= pix_rgb.r;
      vga_g       <= pix_rgb.g;
      vga_b       <= pix_rgb.b;
      vga_hs      <= aligned.hs_n;
      vga_vs      <= aligned.vs_n;
      vga_blank_n <= aligned.visible;
      frame_start <= aligned.first;
      vblank      <= in_vblank;
    end
  end

endmodule

// File: tb/tb_index_frame_reader.sv
// tb_index_frame_reader: drives index_frame_reader with full 640-pixel lines
// and a short frame, a randomized frame-buffer model, and a mid-frame reset.
// Expected outputs come from raster arithmetic over the pixel position and are
// queued per clock; a separate monitor pops and compares them.
module tb_index_frame_reader;

  localparam int LAT = 2;
  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 20,  VF = 3,  VS = 2,  VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int F  = HT * VT;
  localparam int PIX = HV * VV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [18:0] mem_raddr;
  logic [2:0]  mem_rdata;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vblank, frame_start;
`ifdef INDEX_READER_TEST_PATTERN_EN
  logic        test_pattern = 1'b1;
  logic        tp_cur = 1'b1;
`endif

  index_frame_reader #(
    .READ_LATENCY (LAT),
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef INDEX_READER_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  initial forever #5 clock = ~clock;

  // Frame-buffer model: data for an address appears LAT cycles later
  logic [2:0]  mem [0:(1<<19)-1];
  logic [18:0] rd_pipe [LAT];

  always @(posedge clock) begin
    rd_pipe[0] <= mem_raddr;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = mem[rd_pipe[LAT-1]];

  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic        frame_start;
    logic        vblank;
    logic [18:0] raddr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;
  int   k = 0;  // non-reset edges since the last reset edge

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int px(input int p); return (p % F) % HT; endfunction
  function automatic int py(input int p); return (p % F) / HT; endfunction

  // Read address at raster position p: count of visible pixels before it,
  // never beyond the last pixel
  function automatic logic [18:0] exp_addr(input int p);
    int x = px(p);
    int y = py(p);
    int a;
    if (y < VV) a = y * HV + ((x < HV) ? x : HV);
    else        a = PIX - 1;
    if (a > PIX - 1) a = PIX - 1;
    return 19'(a);
  endfunction

  // Expected outputs after the edge just taken, given the reset level it saw
  task automatic push_expected(input logic rst_v);
    exp_t       e;
    int         q, x, y;
    logic       vis;
    logic [2:0] idx;
    logic [9:0] xv;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (rst_v) begin
      k = 0;
    end else begin
      if (k >= LAT) begin
        q = k - LAT;
        x = px(q);
        y = py(q);
        vis = (x < HV) && (y < VV);
        e.blank_n     = vis;
        e.hs          = !((x >= HV + HF) && (x < HV + HF + HS));
        e.vs          = !((y >= VV + VF) && (y < VV + VF + VS));
        e.frame_start = ((q % F) == 0);
        if (vis) begin
          idx = mem[y * HV + x];
`ifdef INDEX_READER_TEST_PATTERN_EN
          if (tp_cur) begin
            xv  = 10'(x);
            idx = xv[8:6];
          end
`endif
          xv  = 10'(x);
          e.r = idx[2] ? 8'hFF : 8'h00;
          e.g = idx[1] ? 8'hFF : 8'h00;
          e.b = idx[0] ? 8'hFF : 8'h00;
        end
      end
      e.vblank = (py(k) >= VV);
      e.raddr  = exp_addr(k + 1);
      k++;
    end
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic rst_v);
    reset = rst_v;
`ifdef INDEX_READER_TEST_PATTERN_EN
    if ($urandom_range(0, 999) == 0) tp_cur = ~tp_cur;
    test_pattern = tp_cur;
`endif
    @(posedge clock);
    edge_cnt++;
    #1;
    push_expected(rst_v);
  endtask

  // Monitor: scoreboard compare plus per-frame sync/blank statistics
  int   fs_times[$];
  int   stat_blank[$], stat_hs[$], stat_vs[$], stat_hfall[$];
  int   blank_cnt, hs_cnt, vs_cnt, frame_off, hfall_off, hs_run;
  int   hs_run_bad = 0;
  int   max_raddr = 0;
  logic fs_seen = 1'b0;
  logic hs_prev = 1'b1;
  exp_t mon_e, mon_a;

  initial begin
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        mon_a = '{r: vga_r, g: vga_g, b: vga_b, hs: vga_hs, vs: vga_vs,
                  blank_n: vga_blank_n, frame_start: frame_start,
                  vblank: vblank, raddr: mem_raddr};
        check($sformatf("sb_edge%0d", edge_cnt), 64'(mon_a), 64'(mon_e));
        if (int'(mem_raddr) > max_raddr) max_raddr = int'(mem_raddr);
        if (frame_start) begin
          fs_times.push_back(edge_cnt);
          if (fs_seen) begin
            stat_blank.push_back(blank_cnt);
            stat_hs.push_back(hs_cnt);
            stat_vs.push_back(vs_cnt);
            stat_hfall.push_back(hfall_off);
          end
          fs_seen = 1'b1;
          blank_cnt = 0; hs_cnt = 0; vs_cnt = 0; frame_off = 0; hfall_off = -1;
        end
        if (vga_blank_n) blank_cnt++;
        if (!vga_vs) vs_cnt++;
        if (!vga_hs) begin
          hs_cnt++;
          hs_run++;
          if (hs_prev && hfall_off < 0) hfall_off = frame_off;
        end else if (!hs_prev) begin
          if (hs_run != HS) hs_run_bad++;
          hs_run = 0;
        end
        hs_prev = vga_hs;
        frame_off++;
      end
      if (reset) begin
        fs_seen = 1'b0;
        hs_run  = 0;
        hs_prev = 1'b1;
      end
    end
  end

  int e0, e_rst;

  initial begin
    for (int a = 0; a < (1 << 19); a++) mem[a] = (a < PIX) ? 3'(a) : 3'd0;

    repeat (4) cycle(1'b1);
    e0 = edge_cnt + 1;

    // First frame, then into the second up to h=300, v=10
    while (k != F + 10 * HT + 300) cycle(1'b0);

    cycle(1'b1);
    e_rst = edge_cnt;
    for (int a = 0; a < PIX; a++) mem[a] = 3'($urandom);

    repeat (F + LAT + 200) cycle(1'b0);
    @(negedge clock);
    #1;

    check("fs_count", 64'(fs_times.size()), 64'd4);
    if (fs_times.size() >= 4) begin
      check("fs_first_cycle", 64'(fs_times[0] - e0 + 1), 64'(LAT + 1));
      check("fs_period_a",    64'(fs_times[1] - fs_times[0]), 64'(F));
      check("fs_after_reset", 64'(fs_times[2] - e_rst), 64'(LAT + 1));
      check("fs_period_b",    64'(fs_times[3] - fs_times[2]), 64'(F));
    end
    check("stat_frames", 64'(stat_blank.size()), 64'd2);
    foreach (stat_blank[i]) begin
      check($sformatf("blank_high_f%0d", i), 64'(stat_blank[i]), 64'(PIX));
      check($sformatf("hs_low_f%0d", i),     64'(stat_hs[i]),    64'(HS * VT));
      check($sformatf("vs_low_f%0d", i),     64'(stat_vs[i]),    64'(VS * HT));
      check($sformatf("hs_fall_f%0d", i),    64'(stat_hfall[i]), 64'(HV + HF));
    end
    check("hs_run_bad", 64'(hs_run_bad), 64'd0);
    check("max_raddr",  64'(max_raddr),  64'(PIX - 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
